polyvec_matrix_expand_stream: RTL and testbench

- Parametrised successor to the fixed K=6/L=5 matrix expander.
- Expands seed rho into the K x L matrix A of Dilithium polynomials using the existing poly_uniform core; the security level is selected at run time.
- Polynomials are streamed out one at a time with a valid/ready handshake, tagged with row/column, instead of being exposed on wide flat buses.
- A 2-entry output buffer lets generation of the next polynomial overlap consumer stalls.

---
 rtl/poly_uniform.sv | 57 +++++
 rtl/polyvec_matrix_expand_stream.sv | 203 ++++++++++++++++++++
 tb/tb_polyvec_matrix_expand_stream.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/poly_uniform.sv
// Behavioural stand-in for the uniform-sampling core: fixed LAT-cycle latency, deterministic
// coefficients in [0, 2^23) derived from (rho, nonce). Same pin interface as the real core.
module poly_uniform #(
  parameter int COEFF_W = 32,
  parameter int N       = 256,
  parameter int LAT     = 8
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [255:0]         rho,
  input  logic [15:0]          nonce,
  output logic [N*COEFF_W-1:0] a_out,
  output logic                 done
);
  localparam int CTW = $clog2(LAT + 1);

  logic [31:0]    fold, seed_q;
  logic [CTW-1:0] ctr_q;
  logic           busy_q, done_q;

  always_comb begin
    fold = '0;
    for (int w = 0; w < 8; w++) fold = fold ^ rho[w*32 +: 32];
  end

  // done_q blocks re-acceptance in the cycle the caller is still holding start high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_q <= '0;
      ctr_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        ctr_q <= ctr_q - CTW'(1);
        if (ctr_q == CTW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end else if (start && !done_q) begin
        busy_q <= 1'b1;
        ctr_q  <= CTW'(LAT);
        seed_q <= fold ^ {nonce, nonce};
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_coef
    logic [31:0] h;
    assign h = seed_q + 32'(k) * 32'h9E37_79B9;
    assign a_out[k*COEFF_W +: COEFF_W] = COEFF_W'((h ^ (h >> 15)) & 32'h007F_FFFF);
  end

  assign done = done_q;
endmodule

// File: rtl/polyvec_matrix_expand_stream.sv
// Streams the K x L matrix A expanded from rho, one row/col-tagged polynomial per valid/ready
// beat through a 2-entry buffer. Optional abort input: MATRIX_EXPAND_ABORT_EN.
module polyvec_matrix_expand_stream #(
  parameter  int COEFF_W = 32,
  parameter  int N       = 256,
  parameter  int K_MAX   = 8,
  parameter  int L_MAX   = 7,
  parameter  int PU_LAT  = 8,
  localparam int POLY_W  = N * COEFF_W,
  localparam int RW      = $clog2(K_MAX),
  localparam int CW      = $clog2(L_MAX)
)(
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [255:0]      rho_in_i,
`ifdef MATRIX_EXPAND_ABORT_EN
  input  logic              abort_i,
`endif
  output logic [POLY_W-1:0] poly_out_o,
  output logic              poly_valid_o,
  input  logic              poly_ready_i,
  output logic [RW-1:0]     poly_row_o,
  output logic [CW-1:0]     poly_col_o,
  output logic              poly_last_o,
  output logic              busy_o,
  output logic              err_o,
  output logic              done_o
);
  localparam int DW = $clog2((K_MAX > L_MAX ? K_MAX : L_MAX) + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_STALL, S_DRAIN, S_DONE
`ifdef MATRIX_EXPAND_ABORT_EN
    , S_ABORT
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     i_q, i_d;
  logic [CW-1:0]     j_q, j_d;
  logic              err_q, err_d;
  logic [DW-1:0]     kdim_q, ldim_q, dec_k, dec_l;
  logic              dec_bad;
  logic [255:0]      rho_q;
  logic [1:0]        cnt_q;
  logic              wr_q, rd_q;
  logic              push, pop, flush, pu_start, pu_done, i_last, j_last;
  logic [POLY_W-1:0] pu_a;
  logic [POLY_W-1:0] ent_poly_q [2];
  logic [RW-1:0]     ent_row_q  [2];
  logic [CW-1:0]     ent_col_q  [2];
  logic              ent_last_q [2];

  poly_uniform #(.COEFF_W(COEFF_W), .N(N), .LAT(PU_LAT)) u_pu (
    .clk(clock_i), .rst(~reset_n_i), .start(pu_start), .rho(rho_q),
    .nonce({8'(i_q), 8'(j_q)}), .a_out(pu_a), .done(pu_done)
  );

  always_comb begin
    dec_k = '0; dec_l = '0; dec_bad = 1'b0;
    case (mode_i)
      2'd0:    begin dec_k = DW'(4); dec_l = DW'(4); end
      2'd1:    begin dec_k = DW'(6); dec_l = DW'(5); end
      2'd2:    begin dec_k = DW'(8); dec_l = DW'(7); end
      default: dec_bad = 1'b1;
    endcase
    if (dec_k > DW'(K_MAX) || dec_l > DW'(L_MAX)) dec_bad = 1'b1;
  end

  assign i_last       = (DW'(i_q) == kdim_q - DW'(1));
  assign j_last       = (DW'(j_q) == ldim_q - DW'(1));
  assign poly_valid_o = (cnt_q != 2'd0);
  assign pop          = poly_valid_o & poly_ready_i;

`ifdef MATRIX_EXPAND_ABORT_EN
  logic pend_q, pend_d;
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) pend_q <= 1'b0;
    else            pend_q <= pend_d;
`endif

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    err_d    = err_q;
    pu_start = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
`ifdef MATRIX_EXPAND_ABORT_EN
    pend_d   = pend_q;
`endif
    case (state_q)
      S_IDLE: if (start_i) begin
        if (dec_bad) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = S_LAUNCH;
          i_d     = '0;
          j_d     = '0;
        end
      end
      S_LAUNCH: begin
        pu_start = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        pu_start = 1'b1;
        if (pu_done) begin
          push = 1'b1;
          if (j_last) begin
            j_d = '0;
            i_d = i_q + RW'(1);
          end else begin
            j_d = j_q + CW'(1);
          end
          // after this push occupancy is cnt+1-pop; a slot is free iff that is below 2
          if (i_last && j_last)          state_d = S_DRAIN;
          else if (cnt_q == 2'd0 || pop) state_d = S_LAUNCH;
          else                           state_d = S_STALL;
        end
      end
      S_STALL: if (pop) state_d = S_LAUNCH;
      S_DRAIN: if (cnt_q == 2'd0) state_d = S_DONE;
      S_DONE: if (!start_i) begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
`ifdef MATRIX_EXPAND_ABORT_EN
      S_ABORT: if (!pend_q || pu_done) begin
        state_d = S_DONE;
        err_d   = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef MATRIX_EXPAND_ABORT_EN
    // a core request is in flight if it is being launched now or running without completion
    if (abort_i && (state_q == S_LAUNCH || state_q == S_WAIT ||
                    state_q == S_STALL  || state_q == S_DRAIN)) begin
      state_d = S_ABORT;
      flush   = 1'b1;
      push    = 1'b0;
      pend_d  = (state_q == S_LAUNCH) || (state_q == S_WAIT && !pu_done);
    end
`endif
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      err_q   <= 1'b0;
      kdim_q  <= '0;
      ldim_q  <= '0;
      rho_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && start_i) begin
        rho_q  <= rho_in_i;
        kdim_q <= dec_k;
        ldim_q <= dec_l;
      end
      if (flush) begin
        cnt_q <= '0;
        wr_q  <= 1'b0;
        rd_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 2'(push) - 2'(pop);
        if (push) wr_q <= ~wr_q;
        if (pop)  rd_q <= ~rd_q;
      end
    end
  end

  // payload needs no reset: every output view of it is gated by poly_valid
  always_ff @(posedge clock_i) begin
    if (push) begin
      ent_poly_q[wr_q] <= pu_a;
      ent_row_q[wr_q]  <= i_q;
      ent_col_q[wr_q]  <= j_q;
      ent_last_q[wr_q] <= i_last & j_last;
    end
  end

  assign poly_out_o  = poly_valid_o ? ent_poly_q[rd_q] : '0;
  assign poly_row_o  = poly_valid_o ? ent_row_q[rd_q]  : '0;
  assign poly_col_o  = poly_valid_o ? ent_col_q[rd_q]  : '0;
  assign poly_last_o = poly_valid_o & ent_last_q[rd_q];
  assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = err_q;
endmodule

// File: tb/tb_polyvec_matrix_expand_stream.sv
// Directed bench for polyvec_matrix_expand_stream: a negedge monitor scores every pop against
// bench-side tags and a reference of the sampling core; main thread drives the scenarios.
module tb_polyvec_matrix_expand_stream;
  localparam int COEFF_W = 32, N = 256, POLY_W = N * COEFF_W, RW = 3, CW = 3;

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b0;
  logic [1:0]        mode = '0;
  logic [255:0]      rho = '0;
  logic [POLY_W-1:0] pout, snap;
  logic              pvalid, plast, busy, err, done;
  logic [RW-1:0]     prow;
  logic [CW-1:0]     pcol;
`ifdef MATRIX_EXPAND_ABORT_EN
  logic              abort = 1'b0;
`endif
  int n_chk = 0, n_err = 0, pops = 0, vld_seen = 0;
  int run_k = 0, run_l = 0, exp_i = 0, exp_j = 0;
  logic [255:0] run_rho = '0;

  always #5 clk = ~clk;

  polyvec_matrix_expand_stream dut (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start), .mode_i(mode), .rho_in_i(rho),
`ifdef MATRIX_EXPAND_ABORT_EN
    .abort_i(abort),
`endif
    .poly_out_o(pout), .poly_valid_o(pvalid), .poly_ready_i(ready),
    .poly_row_o(prow), .poly_col_o(pcol), .poly_last_o(plast),
    .busy_o(busy), .err_o(err), .done_o(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [POLY_W-1:0] ref_poly(input logic [255:0] r, input logic [15:0] nonce);
    logic [31:0] f, h;
    logic [POLY_W-1:0] p;
    f = '0;
    for (int w = 0; w < 8; w++) f = f ^ r[w*32 +: 32];
    for (int k = 0; k < N; k++) begin
      h = (f ^ {nonce, nonce}) + 32'(k) * 32'h9E37_79B9;
      p[k*COEFF_W +: COEFF_W] = (h ^ (h >> 15)) & 32'h007F_FFFF;
    end
    return p;
  endfunction

  function automatic int first_diff(input logic [POLY_W-1:0] a, input logic [POLY_W-1:0] b);
    for (int k = 0; k < N; k++)
      if (a[k*COEFF_W +: COEFF_W] !== b[k*COEFF_W +: COEFF_W]) return k;
    return 0;
  endfunction

  always @(negedge clk) begin : mon
    logic [POLY_W-1:0] ep;
    int d;
    if (pvalid) vld_seen++;
    if (pvalid && ready) begin
      ep = ref_poly(run_rho, {8'(exp_i), 8'(exp_j)});
      d  = first_diff(pout, ep);
      chk("row", 64'(prow), 64'(exp_i));
      chk("col", 64'(pcol), 64'(exp_j));
      chk("poly", 64'(pout[d*COEFF_W +: COEFF_W]), 64'(ep[d*COEFF_W +: COEFF_W]));
      chk("last", 64'(plast), 64'(exp_i == run_k - 1 && exp_j == run_l - 1));
      pops++;
      if (exp_j == run_l - 1) begin exp_j = 0; exp_i++; end
      else exp_j++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic begin_run(input logic [1:0] m, input logic [255:0] r, input int k, input int l);
    run_rho = r; run_k = k; run_l = l; exp_i = 0; exp_j = 0; pops = 0; vld_seen = 0;
    mode = m; rho = r; start = 1'b1;
    tick(); tick();
    mode = ~m; rho = ~r;  // must be ignored once latched
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!done && c < budget) begin tick(); c++; end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  task automatic end_run(input int exp_pops, input logic exp_err);
    chk("pops", 64'(pops), 64'(exp_pops));
    chk("err", 64'(err), 64'(exp_err));
    chk("busy_done", 64'(busy), 64'd0);
    start = 1'b0;
    tick();
    chk("done_clr", 64'(done), 64'd0);
    chk("err_clr", 64'(err), 64'd0);
  endtask

  initial begin
    int c;
    repeat (3) tick();
    chk("rst_valid", 64'(pvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    tick();

    ready = 1'b1;
    begin_run(2'd1, 256'h1, 6, 5);
    wait_done(3000);
    end_run(30, 1'b0);

    begin_run(2'd0, 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 4, 4);
    wait_done(3000);
    end_run(16, 1'b0);

    begin_run(2'd2, (256'hCAFE_F00D << 77) | 256'h5, 8, 7);
    wait_done(5000);
    end_run(56, 1'b0);

    // consumer stall: buffer fills, head must hold
    ready = 1'b0;
    begin_run(2'd2, 256'h5EED_0000_1111_2222, 8, 7);
    c = 0;
    while (!pvalid && c < 200) begin tick(); c++; end
    chk("first_vld", 64'(pvalid), 64'd1);
    snap = pout;
    repeat (5000) tick();
    chk("fill", 64'(dut.cnt_q), 64'd2);
    c = first_diff(pout, snap);
    chk("hold_poly", 64'(pout[c*COEFF_W +: COEFF_W]), 64'(snap[c*COEFF_W +: COEFF_W]));
    chk("hold_tag", 64'({prow, pcol}), 64'd0);
    ready = 1'b1;
    wait_done(5000);
    end_run(56, 1'b0);

    // reserved mode
    vld_seen = 0; pops = 0;
    mode = 2'd3; start = 1'b1;
    tick(); tick();
    chk("m3_done", 64'(done), 64'd1);
    chk("m3_err", 64'(err), 64'd1);
    chk("m3_novld", 64'(vld_seen), 64'd0);
    end_run(0, 1'b1);

    // reset mid-run, then a clean rerun
    begin_run(2'd1, 256'hABCD, 6, 5);
    c = 0;
    while (pops < 3 && c < 2000) begin tick(); c++; end
    repeat (4) tick();
    rst_n = 1'b0; #1;
    chk("mid_rst_valid", 64'(pvalid), 64'd0);
    chk("mid_rst_pout", 64'(|pout), 64'd0);
    chk("mid_rst_tags", 64'({prow, pcol, plast}), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    start = 1'b0;
    tick(); rst_n = 1'b1; tick();
    begin_run(2'd1, 256'h77, 6, 5);
    wait_done(3000);
    end_run(30, 1'b0);

`ifdef MATRIX_EXPAND_ABORT_EN
    begin_run(2'd1, 256'h99, 6, 5);
    c = 0;
    while (pops < 7 && c < 2000) begin tick(); c++; end
    abort = 1'b1; ready = 1'b0;
    tick();
    abort = 1'b0;
    chk("abort_flush", 64'(pvalid), 64'd0);
    ready = 1'b1;
    wait_done(200);
    end_run(7, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
